mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter in front of one data memory.
// Define MEM_INIT_EN to add a power-up sweep writing data = addr to every word.
module mem_arbiter #(
   parameter int W = 8,
   parameter int A = 8
) (
   input  logic         Clk,
   input  logic         ResetN,
   input  logic         Req0,
   input  logic         Req1,
   input  logic         We0,
   input  logic         We1,
   input  logic [A-1:0] Addr0,
   input  logic [A-1:0] Addr1,
   input  logic [1:0]   Off0,
   input  logic [1:0]   Off1,
   input  logic [W-1:0] WData0,
   input  logic [W-1:0] WData1,
   output logic         Gnt0,
   output logic         Gnt1,
   output logic [W-1:0] RData,
   output logic         RValid0,
   output logic         RValid1,
   output logic         Busy,
   output logic         MemWriteEn,
   output logic [A-1:0] MemAddr,
   output logic [1:0]   MemOffset,
   output logic [W-1:0] MemDataIn,
   input  logic [W-1:0] MemDataOut
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
`ifdef MEM_INIT_EN
      ST_INIT   = 2'd2,
`endif
      ST_ACCESS = 2'd1
   } state_t;

`ifdef MEM_INIT_EN
   localparam state_t RESET_ST = ST_INIT;
`else
   localparam state_t RESET_ST = ST_IDLE;
`endif

   state_t       state_q, state_d;
   // port that wins when both request at once
   logic         prio_q, prio_d;
   logic         gnt0_q, gnt0_d;
   logic         gnt1_q, gnt1_d;
   logic         rvalid0_q, rvalid0_d;
   logic         rvalid1_q, rvalid1_d;
   logic [W-1:0] rdata_q, rdata_d;
   logic         we_q, we_d;
   logic [A-1:0] addr_q, addr_d;
   logic [1:0]   off_q, off_d;
   logic [W-1:0] din_q, din_d;
   logic         pick0, pick1;
`ifdef MEM_INIT_EN
   logic         busy_q, busy_d;
   logic [A-1:0] cnt_q, cnt_d;
`endif

   // choose which port, if any, is latched at the coming edge
   always_comb begin
      pick0 = 1'b0;
      pick1 = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            pick0 = Req0 && (!Req1 || !prio_q);
            pick1 = Req1 && (!Req0 || prio_q);
         end
         ST_ACCESS: begin
            // the port being served is masked for one cycle
            pick0 = gnt1_q && Req0;
            pick1 = gnt0_q && Req1;
         end
         default: ;
      endcase
   end

   // next-state, command latch, read capture and init sweep
   always_comb begin
      state_d   = state_q;
      prio_d    = prio_q;
      gnt0_d    = pick0;
      gnt1_d    = pick1;
      rvalid0_d = 1'b0;
      rvalid1_d = 1'b0;
      rdata_d   = rdata_q;
      we_d      = 1'b0;
      addr_d    = addr_q;
      off_d     = off_q;
      din_d     = din_q;
`ifdef MEM_INIT_EN
      busy_d    = 1'b0;
      cnt_d     = cnt_q;
`endif
      if (state_q == ST_ACCESS && !we_q) begin
         rdata_d   = MemDataOut;
         rvalid0_d = gnt0_q;
         rvalid1_d = gnt1_q;
      end
      if (pick0) begin
         state_d = ST_ACCESS;
         prio_d  = 1'b1;
         we_d    = We0;
         addr_d  = Addr0;
         off_d   = Off0;
         din_d   = WData0;
      end else if (pick1) begin
         state_d = ST_ACCESS;
         prio_d  = 1'b0;
         we_d    = We1;
         addr_d  = Addr1;
         off_d   = Off1;
         din_d   = WData1;
      end else if (state_q == ST_ACCESS) begin
         state_d = ST_IDLE;
      end
`ifdef MEM_INIT_EN
      if (state_q == ST_INIT) begin
         // counter wrapping back to zero marks the last word written
         if (busy_q && cnt_q == '0) begin
            state_d = ST_IDLE;
         end else begin
            busy_d = 1'b1;
            we_d   = 1'b1;
            addr_d = cnt_q;
            off_d  = '0;
            din_d  = W'(cnt_q);
            cnt_d  = cnt_q + A'(1);
         end
      end
`endif
   end

   // all state and outputs clear asynchronously, aborting any access
   always_ff @(posedge Clk or negedge ResetN) begin
      if (!ResetN) begin
         state_q   <= RESET_ST;
         prio_q    <= 1'b0;
         gnt0_q    <= 1'b0;
         gnt1_q    <= 1'b0;
         rvalid0_q <= 1'b0;
         rvalid1_q <= 1'b0;
         rdata_q   <= '0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         off_q     <= '0;
         din_q     <= '0;
`ifdef MEM_INIT_EN
         busy_q    <= 1'b0;
         cnt_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         prio_q    <= prio_d;
         gnt0_q    <= gnt0_d;
         gnt1_q    <= gnt1_d;
         rvalid0_q <= rvalid0_d;
         rvalid1_q <= rvalid1_d;
         rdata_q   <= rdata_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         off_q     <= off_d;
         din_q     <= din_d;
`ifdef MEM_INIT_EN
         busy_q    <= busy_d;
         cnt_q     <= cnt_d;
`endif
      end
   end

   assign Gnt0       = gnt0_q;
   assign Gnt1       = gnt1_q;
   assign RValid0    = rvalid0_q;
   assign RValid1    = rvalid1_q;
   assign RData      = rdata_q;
   assign MemWriteEn = we_q;
   assign MemAddr    = addr_q;
   assign MemOffset  = off_q;
   assign MemDataIn  = din_q;
`ifdef MEM_INIT_EN
   assign Busy       = busy_q;
`else
   assign Busy       = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and random checks of mem_arbiter against a
// transaction-level model and a behavioural data memory.
module tb_mem_arbiter;
   localparam int W = 8;
   localparam int A = 8;
   localparam int DEPTH = 1 << A;

   logic         Clk = 1'b0;
   logic         ResetN = 1'b0;
   logic         req [2];
   logic         we_i [2];
   logic [A-1:0] addr_i [2];
   logic [1:0]   off_i [2];
   logic [W-1:0] wd_i [2];
   logic         Gnt0, Gnt1, RValid0, RValid1, Busy, MemWriteEn;
   logic [W-1:0] RData, MemDataIn, MemDataOut;
   logic [A-1:0] MemAddr;
   logic [1:0]   MemOffset;

   logic [W-1:0] dev_mem [DEPTH];
   logic         preload = 1'b1;
   logic [A-1:0] dev_idx;

   int checks = 0;
   int failures = 0;

   int           m_srv;
   int           m_last;
   int           m_rv;
   logic         m_we;
   logic [A-1:0] m_addr;
   logic [1:0]   m_off;
   logic [W-1:0] m_data;
   logic [W-1:0] m_rdata;
   logic [W-1:0] ref_mem [DEPTH];

   mem_arbiter #(.W(W), .A(A)) dut (
      .Clk(Clk), .ResetN(ResetN),
      .Req0(req[0]), .Req1(req[1]),
      .We0(we_i[0]), .We1(we_i[1]),
      .Addr0(addr_i[0]), .Addr1(addr_i[1]),
      .Off0(off_i[0]), .Off1(off_i[1]),
      .WData0(wd_i[0]), .WData1(wd_i[1]),
      .Gnt0(Gnt0), .Gnt1(Gnt1),
      .RData(RData),
      .RValid0(RValid0), .RValid1(RValid1),
      .Busy(Busy),
      .MemWriteEn(MemWriteEn), .MemAddr(MemAddr),
      .MemOffset(MemOffset), .MemDataIn(MemDataIn),
      .MemDataOut(MemDataOut)
   );

   always #5 Clk = ~Clk;

   assign dev_idx = MemAddr + A'(MemOffset);
   assign MemDataOut = dev_mem[dev_idx];

   always @(posedge Clk) begin
      if (preload) begin
         for (int i = 0; i < DEPTH; i++) dev_mem[i] <= W'(i ^ 'h5A);
      end else if (MemWriteEn) begin
         dev_mem[dev_idx] <= MemDataIn;
      end
   end

   function automatic logic [W-1:0] boot_val(int i);
`ifdef MEM_INIT_EN
      return W'(i);
`else
      return W'(i ^ 'h5A);
`endif
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_srv = -1;
      m_last = 1;
      m_rv = -1;
      m_rdata = '0;
   endtask

   task automatic check_outputs();
      chk("gnt0", Gnt0, m_srv == 0);
      chk("gnt1", Gnt1, m_srv == 1);
      chk("mem_we", MemWriteEn, (m_srv >= 0) && m_we);
      if (m_srv >= 0) begin
         chk("mem_addr", MemAddr, m_addr);
         chk("mem_off", MemOffset, m_off);
         if (m_we) chk("mem_din", MemDataIn, m_data);
      end
      chk("rvalid0", RValid0, m_rv == 0);
      chk("rvalid1", RValid1, m_rv == 1);
      chk("rdata", RData, m_rdata);
      chk("busy", Busy, 0);
   endtask

   // apply the served access, pick the next port, clock, compare
   task automatic tick();
      int idx;
      int nxt;
      nxt = -1;
      m_rv = -1;
      if (m_srv >= 0) begin
         idx = (int'(m_addr) + int'(m_off)) % DEPTH;
         if (m_we) ref_mem[idx] = m_data;
         else begin
            m_rdata = ref_mem[idx];
            m_rv = m_srv;
         end
      end
      if (m_srv < 0) begin
         if (req[0] && req[1]) nxt = 1 - m_last;
         else if (req[0]) nxt = 0;
         else if (req[1]) nxt = 1;
      end else if (req[1 - m_srv]) begin
         nxt = 1 - m_srv;
      end
      if (nxt >= 0) begin
         m_we = we_i[nxt];
         m_addr = addr_i[nxt];
         m_off = off_i[nxt];
         m_data = wd_i[nxt];
         m_last = nxt;
      end
      m_srv = nxt;
      @(posedge Clk);
      #1;
      check_outputs();
   endtask

   task automatic release_reset();
      ResetN = 1'b1;
`ifdef MEM_INIT_EN
      for (int i = 0; i < DEPTH; i++) begin
         @(posedge Clk);
         #1;
         chk("init_busy", Busy, 1);
         chk("init_we", MemWriteEn, 1);
         chk("init_addr", MemAddr, i);
         chk("init_off", MemOffset, 0);
         chk("init_din", MemDataIn, W'(i));
         chk("init_gnt", {Gnt0, Gnt1}, 0);
      end
      @(posedge Clk);
      #1;
      chk("init_end_busy", Busy, 0);
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = W'(i);
`endif
      check_outputs();
   endtask

   task automatic new_cmd(int p);
      we_i[p] = 1'($urandom_range(0, 1));
      addr_i[p] = A'($urandom_range(0, 15));
      off_i[p] = 2'($urandom_range(0, 3));
      wd_i[p] = W'($urandom);
   endtask

   task automatic rand_step();
      logic g;
      for (int p = 0; p < 2; p++) begin
         g = (p == 0) ? Gnt0 : Gnt1;
         if (g) begin
            req[p] = ($urandom_range(0, 9) < 3);
            if (req[p]) new_cmd(p);
         end else if (req[p]) begin
            if ($urandom_range(0, 19) == 0) req[p] = 1'b0;
         end else if ($urandom_range(0, 9) < 4) begin
            req[p] = 1'b1;
            new_cmd(p);
         end
      end
   endtask

   initial begin
      for (int p = 0; p < 2; p++) begin
         req[p] = 1'b0;
         we_i[p] = 1'b0;
         addr_i[p] = '0;
         off_i[p] = '0;
         wd_i[p] = '0;
      end
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = W'(i ^ 'h5A);
      model_reset();
      repeat (2) @(posedge Clk);
      #1;
      preload = 1'b0;
      chk("rst_gnt", {Gnt0, Gnt1}, 0);
      chk("rst_rvalid", {RValid0, RValid1}, 0);
      chk("rst_rdata", RData, 0);
      chk("rst_busy", Busy, 0);
      chk("rst_we", MemWriteEn, 0);
      chk("rst_addr", MemAddr, 0);
      chk("rst_off", MemOffset, 0);
      chk("rst_din", MemDataIn, 0);

      // both ports reading from the first cycle after reset
      addr_i[0] = 8'h10;
      addr_i[1] = 8'h30;
      off_i[1] = 2'd1;
      req[0] = 1'b1;
      req[1] = 1'b1;
      release_reset();
      for (int k = 1; k <= 6; k++) begin
         tick();
         chk("alt_gnt0", Gnt0, k % 2 == 1);
         chk("alt_gnt1", Gnt1, k % 2 == 0);
         if (k == 2) begin
            chk("rd10_valid", RValid0, 1);
            chk("rd10_data", RData, boot_val('h10));
         end
         if (k == 3) begin
            chk("rd31_valid", RValid1, 1);
            chk("rd31_data", RData, boot_val('h31));
         end
      end
      req[0] = 1'b0;
      req[1] = 1'b0;
      tick();
      tick();

      // port 0 write then read back
      we_i[0] = 1'b1;
      addr_i[0] = 8'h20;
      off_i[0] = 2'd2;
      wd_i[0] = 8'hA5;
      req[0] = 1'b1;
      tick();
      chk("wr_gnt0", Gnt0, 1);
      chk("wr_we", MemWriteEn, 1);
      chk("wr_addr", MemAddr, 'h20);
      chk("wr_off", MemOffset, 2);
      chk("wr_din", MemDataIn, 'hA5);
      req[0] = 1'b0;
      tick();
      chk("wr_gnt0_end", Gnt0, 0);
      chk("wr_we_end", MemWriteEn, 0);
      we_i[0] = 1'b0;
      req[0] = 1'b1;
      tick();
      chk("rd_gnt0", Gnt0, 1);
      chk("rd_we", MemWriteEn, 0);
      req[0] = 1'b0;
      tick();
      chk("rd_valid", RValid0, 1);
      chk("rd_data", RData, 'hA5);
      tick();
      chk("rd_valid_pulse", RValid0, 0);
      chk("rd_data_hold", RData, 'hA5);

      // lone requester held high: served every other cycle
      req[0] = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         tick();
         chk("solo_gnt0", Gnt0, k % 2 == 1);
      end
      req[0] = 1'b0;
      tick();
      tick();

      repeat (1500) begin
         rand_step();
         tick();
      end
      req[0] = 1'b0;
      req[1] = 1'b0;
      tick();
      tick();

      // reset in the middle of a write access
      we_i[0] = 1'b1;
      addr_i[0] = 8'h40;
      off_i[0] = 2'd1;
      wd_i[0] = ~ref_mem[8'h41];
      req[0] = 1'b1;
      tick();
      chk("abort_gnt0", Gnt0, 1);
      chk("abort_we", MemWriteEn, 1);
      #3;
      ResetN = 1'b0;
      #1;
      chk("abort_we_async", MemWriteEn, 0);
      chk("abort_gnt_async", Gnt0, 0);
      chk("abort_addr_async", MemAddr, 0);
      req[0] = 1'b0;
      @(posedge Clk);
      #1;
      chk("abort_mem", dev_mem[8'h41], ref_mem[8'h41]);
      chk("abort_rvalid", RValid0, 0);
      chk("abort_gnt", Gnt0, 0);
      model_reset();
      release_reset();
      repeat (3) tick();

      repeat (300) begin
         rand_step();
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
